mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Parametrised N-channel arbiter placing several memory masters on one word-addressed memory port. Masters are instruction fetch, data load/store, and a future debug/DMA channel. Memory-side signals keep the existing core memory-interface semantics: re, byte-wise we, word address, rdata. Reads may have multi-cycle latency; per-channel grant and read-valid handshakes replace the single-master, fixed-timing port.

Parameters:
NUM_CH, 2, number of requesting channels (2..8)
ADDR_W, 30, word address width
DATA_W, 32, data width; multiple of 8
RD_LAT, 1, downstream read latency in cycles from mem_re to valid mem_rdata (1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
ch_req  in  NUM_CH  per-channel request
ch_we  in  NUM_CH*DATA_W/8  per-channel byte write enables; all-zero means read
ch_addr  in  NUM_CH*ADDR_W  per-channel word address
ch_wdata  in  NUM_CH*DATA_W  per-channel write data
ch_gnt  out  NUM_CH  one-hot acceptance pulse
ch_rvalid  out  NUM_CH  one-hot read-data-valid pulse
ch_rdata  out  DATA_W  read data, shared; qualified by ch_rvalid
mem_re  out  1  memory read enable
mem_we  out  DATA_W/8  memory byte write enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high while a read is outstanding

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; round-robin pointer=0; outstanding read dropped.
  - While reset is low, ch_gnt, ch_rvalid, mem_re, mem_we and busy are 0.
  - A read cut off by reset never produces ch_rvalid.
- Request rules:
  - A master holds ch_req, ch_we, ch_addr and ch_wdata stable until it sees ch_gnt.
  - ch_gnt is combinational from ch_req and state, and is asserted in the acceptance cycle.
- States:
  - IDLE: arbitration is open.
  - RWAIT: read outstanding; cycle counter runs RD_LAT-1 down to 0.
- Arbitration:
  - Round-robin. Highest priority goes to channel ptr, then ptr+1, and so on, wrapping modulo NUM_CH.
  - On any grant to channel k, ptr <= (k+1) mod NUM_CH.
  - With no request, ptr is unchanged.
- Write accepted at cycle T:
  - mem_we/mem_addr/mem_wdata are driven from the winner in cycle T.
  - No response; state stays IDLE, so back-to-back writes run at 1 per cycle.
- Read accepted at cycle T:
  - mem_re=1 and mem_addr are driven in cycle T.
  - State goes to RWAIT with the owner latched.
  - At cycle T+RD_LAT: ch_rvalid[owner]=1 and ch_rdata=mem_rdata; state returns to IDLE in the same cycle.
- Arbitration inside RWAIT:
  - During T+1..T+RD_LAT-1: no grants; mem_re=0 and mem_we=0.
  - At T+RD_LAT: arbitration is open, so a new grant may coincide with the rvalid (zero-bubble).
- busy=1 from T+1 through T+RD_LAT inclusive.
- Memory idle outputs: when no grant, mem_re=0 and mem_we=0; mem_addr and mem_wdata hold channel ptr's values (don't-care).
- ch_rdata outside rvalid: don't-care; the bench checks it only when ch_rvalid is set.
- Simultaneous requests from all channels with ptr==NUM_CH-1: channel NUM_CH-1 wins.
- Pointer wrap: ptr wraps to 0.

Optional Feature:
MEM_ARBITER_PERF_EN:
- Defined: adds output stall_cnt, width NUM_CH*16.
  - One saturating 16-bit counter per channel.
  - Increments each cycle that ch_req[k]=1 and ch_gnt[k]=0.
  - Holds at 16'hFFFF; clears on reset.
- Undefined: the port and counters are absent, with identical arbitration behaviour.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state enum (IDLE, RWAIT)
  - bytes-per-word function DATA_W/8
  - latency counter width constant clog2(4)
  - perf counter width constant 16
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Reused by the later interrupt controller.

Test Plan:
- Single write, NUM_CH=2, ch0 req, we=4'b1111, addr=0x10, wdata=0xDEADBEEF -> same-cycle ch_gnt=2'b01, mem_we=4'b1111, mem_addr=0x10, mem_wdata=0xDEADBEEF; no rvalid.
- Read with RD_LAT=3, ch1 addr=0x20, memory returns 0x12345678 -> gnt at T; mem_re only at T; busy T+1..T+3; ch_rvalid=2'b10 and ch_rdata=0x12345678 at T+3.
- Fairness with NUM_CH=4: all channels hold write requests continuously -> grants in order 0,1,2,3,0 over 5 cycles.
- Zero-bubble: ch0 read (RD_LAT=1) then ch1 write pending -> cycle T+1 shows ch_rvalid[0]=1 and ch_gnt[1]=1 together.
- Reset mid-read: read accepted at T with RD_LAT=4; reset low at T+2 for 1 cycle -> no ch_rvalid ever; ptr=0 afterwards; all outputs 0 during reset.
- PERF (macro defined): ch1 blocked 5 cycles behind ch0 reads -> stall_cnt[31:16]=5; counter saturates at 0xFFFF under a forced long stall.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRwait
    } state_e;

    // Wide enough to count down the longest supported read latency (4).
    localparam int unsigned LatCntW = $clog2(4);

    // Width of each per-channel stall counter.
    localparam int unsigned PerfCntW = 16;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: the first request at or after ptr_i wins.
module mem_arbiter_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    int unsigned cand;
    logic        found;

    // Scan from ptr_i upwards, wrapping, and take the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(ptr_i) + i) % NumReq;
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found = 1'b1;
                idx_o = cand[IdxW-1:0];
                gnt_o = NumReq'(1) << cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter onto one word-addressed memory port.
// Writes complete in the grant cycle; reads hold the port for RD_LAT cycles
// and return data on the owner's ch_rvalid_o, with arbitration reopened in
// the return cycle so a new grant can overlap it.
// Optional: define MEM_ARBITER_PERF_EN to add per-channel stall counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_CH-1:0]                  ch_req_i,
    input  logic [NUM_CH*(DATA_W/8)-1:0]       ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]           ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]           ch_wdata_i,
    output logic [NUM_CH-1:0]                  ch_gnt_o,
    output logic [NUM_CH-1:0]                  ch_rvalid_o,
    output logic [DATA_W-1:0]                  ch_rdata_o,
    output logic                               mem_re_o,
    output logic [DATA_W/8-1:0]                mem_we_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    output logic [DATA_W-1:0]                  mem_wdata_o,
    input  logic [DATA_W-1:0]                  mem_rdata_i,
    output logic                               busy_o
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [NUM_CH*PerfCntW-1:0]         stall_cnt_o
`endif
);

    localparam int unsigned BeW  = bytes_per_word(DATA_W);
    localparam int unsigned IdxW = $clog2(NUM_CH);

    state_e               state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [LatCntW-1:0]   cnt_q, cnt_d;

    logic                 rd_done;
    logic                 arb_open;
    logic [NUM_CH-1:0]    pick_req;
    logic [NUM_CH-1:0]    pick_gnt;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_any;
    logic [IdxW-1:0]      sel;
    logic [BeW-1:0]       sel_we;

    // Arbitration is open when idle or in the read-return cycle; closed in reset.
    always_comb begin
        rd_done  = (state_q == StRwait) && (cnt_q == '0);
        arb_open = (state_q == StIdle) || rd_done;
        pick_req = (rst_ni && arb_open) ? ch_req_i : '0;
    end

    mem_arbiter_rr_pick #(
        .NumReq (NUM_CH),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .req_i  (pick_req),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Memory-side mux and channel responses; address/data follow ptr when idle.
    always_comb begin
        sel         = pick_any ? pick_idx : ptr_q;
        sel_we      = ch_we_i[sel*BeW +: BeW];
        ch_gnt_o    = pick_gnt;
        mem_we_o    = pick_any ? sel_we : '0;
        mem_re_o    = pick_any && (sel_we == '0);
        mem_addr_o  = ch_addr_i[sel*ADDR_W +: ADDR_W];
        mem_wdata_o = ch_wdata_i[sel*DATA_W +: DATA_W];
        ch_rvalid_o = (rst_ni && rd_done) ? (NUM_CH'(1) << owner_q) : '0;
        ch_rdata_o  = mem_rdata_i;
        busy_o      = rst_ni && (state_q == StRwait);
    end

    // Next state: finish an outstanding read, then take any new grant.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (state_q == StRwait) begin
            if (rd_done) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (pick_any) begin
            ptr_d = (pick_idx == IdxW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
            if (mem_re_o) begin
                state_d = StRwait;
                owner_d = pick_idx;
                cnt_d   = LatCntW'(RD_LAT - 1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
        logic [PerfCntW-1:0] stall_q, stall_d;

        // Count cycles spent requesting without a grant, saturating at all-ones.
        always_comb begin
            stall_d = stall_q;
            if (ch_req_i[g] && !ch_gnt_o[g] && (stall_q != '1)) begin
                stall_d = stall_q + 1'b1;
            end
        end

        // Stall counter register.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_d;
            end
        end

        assign stall_cnt_o[g*PerfCntW +: PerfCntW] = stall_q;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: 4 channels, 3-cycle read latency.
module tb_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LAT = 3;

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      ch_req;
    logic [N*BW-1:0]   ch_we;
    logic [N*AW-1:0]   ch_addr;
    logic [N*DW-1:0]   ch_wdata;
    logic [N-1:0]      ch_gnt;
    logic [N-1:0]      ch_rvalid;
    logic [DW-1:0]     ch_rdata;
    logic              mem_re;
    logic [BW-1:0]     mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
`ifdef MEM_ARBITER_PERF_EN
    logic [N*16-1:0]   stall_cnt;
    logic [15:0]       m_stall [N];
`endif

    // Per-channel stimulus.
    logic              req   [N];
    logic [BW-1:0]     we    [N];
    logic [AW-1:0]     addr  [N];
    logic [DW-1:0]     wdata [N];
    logic              clr   [N];
    logic              hold;

    // Reference model and scoreboard.
    int                m_ptr;
    logic              m_rw;
    int                m_left;
    exp_t              sb [$];
    int                glog [$];
    int                cyc;
    logic              zb_seen;
    int                n_chk;
    int                n_bad;

    logic [AW-1:0]     pipe [LAT];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_req[i]               = req[i];
            ch_we[i*BW +: BW]       = we[i];
            ch_addr[i*AW +: AW]     = addr[i];
            ch_wdata[i*DW +: DW]    = wdata[i];
        end
    end

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        if (a == 30'h20) return 32'h1234_5678;
        return {2'b00, a} ^ 32'h5A5A_5A5A;
    endfunction

    // Memory with LAT-cycle read latency.
    always @(posedge clk) begin
        pipe[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = mem_val(pipe[LAT-1]);

    mem_arbiter #(
        .NUM_CH (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (LAT)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ch_req_i    (ch_req),
        .ch_we_i     (ch_we),
        .ch_addr_i   (ch_addr),
        .ch_wdata_i  (ch_wdata),
        .ch_gnt_o    (ch_gnt),
        .ch_rvalid_o (ch_rvalid),
        .ch_rdata_o  (ch_rdata),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: compare at negedge against the model, then advance inputs.
    task automatic step();
        int       w;
        logic [N-1:0] eg;
        exp_t     e;
        @(negedge clk);
        w  = -1;
        eg = '0;
        if (rst_n && (!m_rw || m_left == 0)) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (w < 0 && req[c]) w = c;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        check_eq("gnt", 64'(ch_gnt), 64'(eg));
        if (w >= 0) begin
            check_eq("mem_we", 64'(mem_we), 64'(we[w]));
            check_eq("mem_addr", 64'(mem_addr), 64'(addr[w]));
            if (we[w] == '0) begin
                check_eq("mem_re_rd", 64'(mem_re), 64'd1);
                e.ch   = w;
                e.data = mem_val(addr[w]);
                e.due  = cyc + LAT;
                sb.push_back(e);
            end else begin
                check_eq("mem_re_wr", 64'(mem_re), 64'd0);
                check_eq("mem_wdata", 64'(mem_wdata), 64'(wdata[w]));
            end
            glog.push_back(w);
            if (!hold) clr[w] = 1'b1;
        end else begin
            check_eq("idle_re", 64'(mem_re), 64'd0);
            check_eq("idle_we", 64'(mem_we), 64'd0);
        end
        if (!rst_n) begin
            check_eq("rst_rvalid", 64'(ch_rvalid), 64'd0);
        end else if (ch_rvalid != '0) begin
            if (sb.size() == 0) begin
                check_eq("rv_spurious", 64'(ch_rvalid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rv_ch", 64'(ch_rvalid), 64'(1) << e.ch);
                check_eq("rv_cyc", 64'(cyc), 64'(e.due));
                check_eq("rdata", 64'(ch_rdata), 64'(e.data));
                if (ch_gnt != '0) zb_seen = 1'b1;
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq("rv_missing", 64'(ch_rvalid), 64'(1) << e.ch);
        end
        check_eq("busy", 64'(busy), 64'(rst_n && m_rw));
`ifdef MEM_ARBITER_PERF_EN
        if (rst_n) begin
            for (int k = 0; k < N; k++)
                check_eq("stall_cnt", 64'(stall_cnt[k*16 +: 16]), 64'(m_stall[k]));
        end
        for (int k = 0; k < N; k++) begin
            if (!rst_n) m_stall[k] = '0;
            else if (req[k] && !eg[k] && m_stall[k] != 16'hFFFF) m_stall[k] = m_stall[k] + 1'b1;
        end
`endif
        if (!rst_n) begin
            m_ptr = 0;
            m_rw  = 1'b0;
            sb.delete();
        end else begin
            if (m_rw) begin
                if (m_left == 0) m_rw = 1'b0;
                else m_left--;
            end
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (we[w] == '0) begin
                    m_rw   = 1'b1;
                    m_left = LAT - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (clr[k]) begin
                req[k] = 1'b0;
                clr[k] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int ch, input logic [BW-1:0] w_be, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[ch]   = 1'b1;
        we[ch]    = w_be;
        addr[ch]  = a;
        wdata[ch] = d;
    endtask

    initial begin
        int exp_f [5];
        exp_f = '{0, 1, 2, 3, 0};
        n_chk = 0; n_bad = 0; cyc = 0;
        m_ptr = 0; m_rw = 1'b0; m_left = 0;
        hold = 1'b0; zb_seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; we[i] = '0; addr[i] = '0; wdata[i] = '0; clr[i] = 1'b0;
`ifdef MEM_ARBITER_PERF_EN
            m_stall[i] = '0;
`endif
        end

        // Reset with a pending request: all outputs must stay low.
        rst_n = 1'b0;
        set_req(1, 4'hF, 30'h1, 32'h1);
        step();
        step();
        req[1] = 1'b0;
        rst_n = 1'b1;
        step();

        // Fairness: all four hold write requests.
        hold = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'hF, AW'(32'h100 + i), 32'hA000_0000 + i);
        glog.delete();
        repeat (5) step();
        hold = 1'b0;
        for (int i = 0; i < N; i++) req[i] = 1'b0;
        check_eq("fair_n", 64'(glog.size()), 64'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check_eq("fair_order", 64'(glog[i]), 64'(exp_f[i]));

        // Single write from ch0.
        set_req(0, 4'hF, 30'h10, 32'hDEAD_BEEF);
        step();
        step();

        // Read from ch1 returning 0x12345678 after LAT cycles.
        set_req(1, 4'h0, 30'h20, 32'h0);
        repeat (LAT + 2) step();

        // Zero-bubble: ch0 read, then ch1 write waiting for the return cycle.
        zb_seen = 1'b0;
        set_req(0, 4'h0, 30'h30, 32'h0);
        step();
        set_req(1, 4'h3, 30'h31, 32'hCAFE_F00D);
        repeat (LAT + 1) step();
        check_eq("zero_bubble", 64'(zb_seen), 64'd1);

        // Reset in the middle of a ch2 read; ptr must restart at 0.
        set_req(2, 4'h0, 30'h44, 32'h0);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (LAT + 2) step();
        glog.delete();
        for (int i = 0; i < N; i++) set_req(i, 4'h1, AW'(32'h200 + i), 32'hB000_0000 + i);
        step();
        check_eq("ptr_after_rst", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
        repeat (N + 1) step();

        // Random mixed traffic.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(2) == 0) begin
                    set_req(i, ($urandom_range(1) == 0) ? 4'h0 : BW'($urandom_range(15, 1)),
                            AW'($urandom), $urandom);
                end
            end
            step();
        end
        for (int i = 0; i < N; i++) req[i] = 1'b0;
        repeat (LAT + 3) step();
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
